// File: rtl/homo_result_reader_pkg.sv
// Shared definitions for the homomorphic result reader: default sizes and
// the bit layout software uses when it packs the status flags into a word.
package homo_result_reader_pkg;

    localparam int HRR_DW    = 32;
    localparam int HRR_DEPTH = 16;
    localparam int HRR_AW    = 4;

    localparam int STAT_EMPTY_BIT     = 0;
    localparam int STAT_FULL_BIT      = 1;
    localparam int STAT_OVERFLOW_BIT  = 2;
    localparam int STAT_UNDERFLOW_BIT = 3;

    // Pack the four status flags into the CPU-visible nibble.
    function automatic logic [3:0] pack_status(
        input logic empty,
        input logic full,
        input logic overflow,
        input logic underflow
    );
        logic [3:0] s;
        s                     = 4'b0000;
        s[STAT_EMPTY_BIT]     = empty;
        s[STAT_FULL_BIT]      = full;
        s[STAT_OVERFLOW_BIT]  = overflow;
        s[STAT_UNDERFLOW_BIT] = underflow;
        return s;
    endfunction

endpackage

// File: rtl/homo_result_reader_sync_fifo.sv
// Synchronous FIFO: storage, pointers, registered occupancy and the
// push/pop acceptance rules. A push into a full FIFO is still accepted
// when a pop is accepted in the same cycle; a pop on empty is refused
// even if a push arrives together with it (no bypass).
module sync_fifo
    import homo_result_reader_pkg::*;
#(
    parameter int DEPTH = HRR_DEPTH,
    parameter int DW    = HRR_DW,
    parameter int AW    = HRR_AW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_push_ok,
    output logic          o_pop_ok,
    output logic [AW:0]   o_count,
    output logic          o_empty,
    output logic          o_full
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_empty;
    logic          r_full;

    logic          w_push_ok;
    logic          w_pop_ok;
    logic [AW:0]   w_count_nxt;

    // Acceptance of this cycle's push/pop and the resulting occupancy.
    always_comb begin
        w_pop_ok    = 1'b0;
        w_push_ok   = 1'b0;
        w_count_nxt = r_count;
        w_pop_ok    = i_pop && !r_empty;
        w_push_ok   = i_push && (!r_full || w_pop_ok);
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage write; contents are left untouched by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and registered occupancy/empty/full; pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == (AW+1)'(0));
            r_full  <= (w_count_nxt == C_DEPTH);
        end
    end

    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_push_ok = w_push_ok;
    assign o_pop_ok  = w_pop_ok;
    assign o_count   = r_count;
    assign o_empty   = r_empty;
    assign o_full    = r_full;

endmodule

// File: rtl/homo_result_reader.sv
// Consumer end of the homomorphic core's output stream. Buffers words in a
// FIFO, exposes a latency-1 registered read port to the CPU, and keeps
// sticky overflow/underflow flags plus a running accepted-word total.
module homo_result_reader
    import homo_result_reader_pkg::*;
#(
    parameter int DEPTH = HRR_DEPTH,
    parameter int AW    = HRR_AW,
    parameter int DW    = HRR_DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] in_data,
    input  logic          in_we,
    input  logic          rd_req,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          flag_clr,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow,
    output logic [31:0]   total
);

    logic [DW-1:0] w_fifo_rdata;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic [AW:0]   w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_ovf_set;
    logic          w_udf_set;

    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic          r_overflow;
    logic          r_underflow;
    logic [31:0]   r_total;

    sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_fifo (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_push    (in_we),
        .i_wdata   (in_data),
        .i_pop     (rd_req),
        .o_rdata   (w_fifo_rdata),
        .o_push_ok (w_push_ok),
        .o_pop_ok  (w_pop_ok),
        .o_count   (w_count),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    // Flag-setting events: a refused write or a refused read this cycle.
    always_comb begin
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        w_ovf_set = in_we && !w_push_ok;
        w_udf_set = rd_req && !w_pop_ok;
    end

    // Registered read port: one-cycle valid pulse, data held between pops.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_ok;
            if (w_pop_ok) begin
                r_rd_data <= w_fifo_rdata;
            end
        end
    end

    // Sticky flags; a new event in the same cycle as a clear wins.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (flag_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end else if (flag_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Accepted-word counter; wraps silently at 2^32.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_total <= 32'd0;
        end else if (w_push_ok) begin
            r_total <= r_total + 32'd1;
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign count     = w_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign total     = r_total;

endmodule

// File: tb/tb_homo_result_reader.sv
// Directed self-checking bench for homo_result_reader (DEPTH=16).
module tb_homo_result_reader;

    logic        CLK;
    logic        RST;
    logic [31:0] in_data;
    logic        in_we;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        flag_clr;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;
    logic [31:0] total;

    int n_cmp = 0;
    int n_err = 0;

    homo_result_reader #(.DEPTH(16), .AW(4), .DW(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (in_data),
        .in_we     (in_we),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .flag_clr  (flag_clr),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .total     (total)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock: inputs already set are sampled at the edge, outputs read 1 after.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0; in_we = 1'b0; rd_req = 1'b0; flag_clr = 1'b0; in_data = 32'd0;
        cyc(); cyc();
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0; in_we = 1'b1; in_data = 32'h800; rd_req = 1'b0; flag_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cyc();
            n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count cyc%0d got %0d want 0", k, count); end
            n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty cyc%0d got %b want 1", k, empty); end
            n_cmp++; if (total !== 32'd0) begin n_err++; $display("FAIL reset_total cyc%0d got %0d want 0", k, total); end
            n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid cyc%0d got %b want 0", k, rd_valid); end
            n_cmp++; if (full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL reset_flags got f%b o%b u%b want 000", full, overflow, underflow); end
        end
        RST = 1'b1;
        cyc();
        in_we = 1'b0;
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL post_reset_count got %0d want 1", count); end
    endtask

    task automatic test_single();
        do_reset();
        in_we = 1'b1; in_data = 32'h0000_0800;
        cyc();
        in_we = 1'b0; rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", rd_valid); end
        n_cmp++; if (rd_data !== 32'h0000_0800) begin n_err++; $display("FAIL single_data got %h want 00000800", rd_data); end
        n_cmp++; if (count !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL single_count got %0d/e%b want 0/e1", count, empty); end
        n_cmp++; if (total !== 32'd1) begin n_err++; $display("FAIL single_total got %0d want 1", total); end
        cyc();
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 32'h0000_0800) begin n_err++; $display("FAIL single_hold got %h want 00000800", rd_data); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            in_we = 1'b1; in_data = 32'h200 + 32'(i);
            cyc();
        end
        in_we = 1'b0;
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", full); end
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fill_count got %0d want 16", count); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_overflow got %b want 1", overflow); end
        n_cmp++; if (total !== 32'd16) begin n_err++; $display("FAIL fill_total got %0d want 16", total); end
        for (int i = 0; i < 16; i++) begin
            rd_req = 1'b1;
            cyc();
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h200 + 32'(i)) begin
                n_err++; $display("FAIL fill_drain[%0d] got v%b %h want v1 %h", i, rd_valid, rd_data, 32'h200 + 32'(i));
            end
        end
        rd_req = 1'b0; flag_clr = 1'b1;
        cyc();
        flag_clr = 1'b0;
        n_cmp++; if (empty !== 1'b1 || rd_valid !== 1'b0) begin n_err++; $display("FAIL fill_end got e%b v%b want e1 v0", empty, rd_valid); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_ovf_clr got %b want 0", overflow); end
    endtask

    task automatic test_simul_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_we = 1'b1; in_data = 32'h200 + 32'(i);
            cyc();
        end
        in_we = 1'b1; in_data = 32'h4A0; rd_req = 1'b1;
        cyc();
        in_we = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL simul_ovf got %b want 0", overflow); end
        n_cmp++; if (count !== 5'd16 || full !== 1'b1) begin n_err++; $display("FAIL simul_count got %0d/f%b want 16/f1", count, full); end
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h200) begin n_err++; $display("FAIL simul_pop got v%b %h want v1 00000200", rd_valid, rd_data); end
        n_cmp++; if (total !== 32'd17) begin n_err++; $display("FAIL simul_total got %0d want 17", total); end
        for (int i = 1; i <= 16; i++) begin
            logic [31:0] exp_w;
            exp_w = (i == 16) ? 32'h4A0 : 32'h200 + 32'(i);
            cyc();
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp_w) begin
                n_err++; $display("FAIL simul_drain[%0d] got v%b %h want v1 %h", i, rd_valid, rd_data, exp_w);
            end
        end
        rd_req = 1'b0;
        cyc();
        n_cmp++; if (empty !== 1'b1 || underflow !== 1'b0) begin n_err++; $display("FAIL simul_end got e%b u%b want e1 u0", empty, underflow); end
    endtask

    task automatic test_underflow_clear();
        do_reset();
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_set got %b want 1", underflow); end
        n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 32'd0) begin n_err++; $display("FAIL udf_read got v%b %h want v0 00000000", rd_valid, rd_data); end
        flag_clr = 1'b1;
        cyc();
        flag_clr = 1'b0;
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL udf_clear got %b want 0", underflow); end
        flag_clr = 1'b1; rd_req = 1'b1;
        cyc();
        flag_clr = 1'b0; rd_req = 1'b0;
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_set_wins got %b want 1", underflow); end
        in_we = 1'b1; in_data = 32'h55; rd_req = 1'b1;
        cyc();
        in_we = 1'b0; rd_req = 1'b0;
        n_cmp++; if (count !== 5'd1 || rd_valid !== 1'b0) begin n_err++; $display("FAIL udf_no_bypass got %0d/v%b want 1/v0", count, rd_valid); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            in_we = 1'b1; in_data = 32'h6B0 + 32'(i);
            rd_req = (i >= 5);
            cyc();
            if (i >= 5) begin
                n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h6B0 + 32'(i - 5)) begin
                    n_err++; $display("FAIL wrap[%0d] got v%b %h want v1 %h", i, rd_valid, rd_data, 32'h6B0 + 32'(i - 5));
                end
            end
        end
        in_we = 1'b0; rd_req = 1'b0;
        n_cmp++; if (count !== 5'd5) begin n_err++; $display("FAIL wrap_count got %0d want 5", count); end
        n_cmp++; if (total !== 32'd40) begin n_err++; $display("FAIL wrap_total got %0d want 40", total); end
        RST = 1'b0; rd_req = 1'b1;
        cyc();
        n_cmp++; if (count !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL midrst_count got %0d/e%b want 0/e1", count, empty); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", rd_valid); end
        RST = 1'b1; rd_req = 1'b0;
        cyc();
        n_cmp++; if (rd_valid !== 1'b0 || total !== 32'd0) begin n_err++; $display("FAIL midrst_after got v%b t%0d want v0 t0", rd_valid, total); end
    endtask

    initial begin
        RST = 1'b0; in_we = 1'b0; rd_req = 1'b0; flag_clr = 1'b0; in_data = 32'd0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_simul_full();
        test_underflow_clear();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
